// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among 4 requesters (load M, load Q, wait, respond).
// Define BOOTH_ARB_TIMEOUT_EN to add a WAIT watchdog that answers with rsp_err after TMO cycles.
module booth_mul_arbiter #(
    parameter int W   = 16,
    parameter int TMO = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [4*W-1:0]   op_a,
    input  logic [4*W-1:0]   op_b,
    output logic [3:0]       gnt,
    output logic [3:0]       rsp_valid,
    output logic [2*W-1:0]   rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic             mul_start,
    output logic [W-1:0]     mul_data,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_result
);

    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] gidx;
    logic [1:0] sel;
    logic       sel_vld;
    logic       tmo_hit;

    // Walk downward so the lowest offset from ptr is the one that sticks.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[2'(ptr + 2'(k))]) begin
                sel     = 2'(ptr + 2'(k));
                sel_vld = 1'b1;
            end
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] wdog;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdog <= '0;
        else if (state == WAIT && !mul_done)
            wdog <= wdog + 1'b1;
        else
            wdog <= '0;
    end

    assign tmo_hit = (state == WAIT) && !mul_done && (wdog == CW'(TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = LOAD_M;
            LOAD_M:  state_nxt = LOAD_Q;
            LOAD_Q:  state_nxt = WAIT;
            WAIT:    if (mul_done || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Outputs are registered one edge ahead so each lines up with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            mul_start <= 1'b0;
            mul_data  <= '0;
        end else begin
            state     <= state_nxt;
            mul_start <= 1'b0;
            mul_data  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gidx      <= sel;
                        gnt       <= 4'b0001 << sel;
                        mul_start <= 1'b1;
                        mul_data  <= op_a[int'(sel)*W +: W];
                    end
                end
                LOAD_M: mul_data <= op_b[int'(gidx)*W +: W];
                WAIT: begin
                    if (mul_done) begin
                        rsp_valid <= 4'b0001 << gidx;
                        rsp_data  <= mul_result;
                    end else if (tmo_hit) begin
                        rsp_valid <= 4'b0001 << gidx;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    gnt <= '0;
                    ptr <= gidx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter; the bench itself plays the shared multiplier.
module tb_booth_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        mul_start;
    logic [15:0] mul_data;
    logic        mul_done;
    logic [31:0] mul_result;

    int n_cmp = 0;
    int n_err = 0;

    booth_mul_arbiter #(.W(16), .TMO(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_data   (mul_data),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mul_start"}, mul_start, 0);
        chk({tag, "_mul_data"}, mul_data, 0);
    endtask

    // Starts from IDLE with req already driven; ends one cycle after RESP (back in IDLE).
    task automatic run_op(input string tag, input logic [3:0] eg, input int wn,
                          input bit early, input logic [31:0] res);
        int gi;
        gi = (eg == 4'b0001) ? 0 : (eg == 4'b0010) ? 1 : (eg == 4'b0100) ? 2 : 3;
        tick;
        chk({tag, "_gnt"}, gnt, eg);
        chk({tag, "_start_m"}, mul_start, 1);
        chk({tag, "_data_a"}, mul_data, op_a[gi*16 +: 16]);
        chk({tag, "_busy"}, busy, 1);
        tick;
        chk({tag, "_start_q"}, mul_start, 0);
        chk({tag, "_data_b"}, mul_data, op_b[gi*16 +: 16]);
        if (early) begin
            mul_done   = 1'b1;
            mul_result = 32'hDEADBEEF;
        end
        tick;
        mul_done = 1'b0;
        chk({tag, "_data_wait"}, mul_data, 0);
        chk({tag, "_rsp_wait"}, rsp_valid, 0);
        for (int i = 1; i < wn; i++) begin
            tick;
            chk({tag, "_rsp_wait"}, rsp_valid, 0);
        end
        mul_done   = 1'b1;
        mul_result = res;
        tick;
        mul_done = 1'b0;
        chk({tag, "_rsp_valid"}, rsp_valid, eg);
        chk({tag, "_rsp_data"}, rsp_data, res);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_gnt_resp"}, gnt, eg);
        tick;
        chk_all_zero({tag, "_idle"});
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        op_a       = '0;
        op_b       = '0;
        mul_done   = 1'b0;
        mul_result = '0;
        #2;
        chk_all_zero("reset");
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk_all_zero("post_reset");

        // 32 * -12 = -384, multiplier finishes on the 17th WAIT cycle
        op_a[15:0] = 16'd32;
        op_b[15:0] = 16'hFFF4;
        req        = 4'b0001;
        run_op("single", 4'b0001, 17, 1'b0, 32'hFFFFFE80);
        req = 4'b0000;

        rst = 1'b1;
        tick;
        rst = 1'b0;
        op_a = {16'd4, 16'd3, 16'd2, 16'd1};
        op_b = {16'd8, 16'd7, 16'd6, 16'd5};
        req  = 4'b1111;
        run_op("rr0", 4'b0001, 1, 1'b0, 32'd5);
        run_op("rr1", 4'b0010, 2, 1'b0, 32'd12);
        run_op("rr2", 4'b0100, 1, 1'b0, 32'd21);
        run_op("rr3", 4'b1000, 3, 1'b0, 32'd32);
        req = 4'b0010;
        run_op("wrap_pre", 4'b0010, 1, 1'b0, 32'd12);
        req = 4'b0011;
        run_op("wrap", 4'b0001, 1, 1'b0, 32'd5);
        req = 4'b0000;

        // stray completion while idle must not start or answer anything
        mul_done   = 1'b1;
        mul_result = 32'h0BAD0BAD;
        tick;
        mul_done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_rsp", rsp_valid, 0);
        tick;
        chk("idle_done_rsp2", rsp_valid, 0);

        req = 4'b0100;
        run_op("early_done", 4'b0100, 5, 1'b1, 32'd21);

        req = 4'b0010;
        tick;
        chk("rst_mid_gnt", gnt, 4'b0010);
        tick;
        tick;
        tick;
        chk("rst_mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        tick;
        chk("rst_hold_rsp", rsp_valid, 0);
        mul_done   = 1'b1;
        mul_result = 32'h12345678;
        tick;
        chk("rst_hold_rsp2", rsp_valid, 0);
        mul_done = 1'b0;
        rst      = 1'b0;
        req      = 4'b0000;
        tick;
        chk_all_zero("rst_release");
        tick;
        chk("rst_release_rsp", rsp_valid, 0);
        req = 4'b0100;
        run_op("after_rst", 4'b0100, 1, 1'b0, 32'd21);
        req = 4'b1010;
        run_op("after_rst_rr", 4'b1000, 2, 1'b0, 32'd32);
        req = 4'b0000;

`ifdef BOOTH_ARB_TIMEOUT_EN
        req = 4'b0001;
        tick;
        chk("tmo_gnt", gnt, 4'b0001);
        tick;
        tick;
        req = 4'b0000;
        for (int i = 1; i < 64; i++) begin
            chk("tmo_wait_rsp", rsp_valid, 0);
            tick;
        end
        chk("tmo_wait_last", rsp_valid, 0);
        tick;
        chk("tmo_rsp_valid", rsp_valid, 4'b0001);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_data", rsp_data, 0);
        tick;
        chk_all_zero("tmo_idle");
        req = 4'b0011;
        run_op("tmo_ptr", 4'b0010, 1, 1'b0, 32'd12);
        req = 4'b0000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
